// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the icache/dcache memory arbiter: bus widths, FSM state
// encodings, owner encoding and the latched request record.
package mem_arbiter_pkg;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MASK_W     = 4;
  localparam int BEAT_CNT_W = 4;   // holds 0..15, enough for BEATS up to 16
  localparam int D_RUN_W    = 4;   // holds 0..15, enough for MAX_D_RUN up to 15

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  localparam logic OWNER_DC = 1'b0;
  localparam logic OWNER_IC = 1'b1;

  typedef struct packed {
    logic              owner;
    logic              rnw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } req_fields_t;

  localparam int REQ_W = $bits(req_fields_t);

endpackage

// File: rtl/mem_arbiter_req_latch.sv
// Clock-enabled holding register for the granted request; cleared by reset so
// the memory-side request fields read as zero while the block is in reset.
module req_latch #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;

  // NOTE: this datapath register is reset on purpose; without it mem_req_* would
  // carry stale or X values out of reset instead of zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (en_i) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values,
      // independent of the order in which always_ff blocks are evaluated.
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (icache/dcache) single-outstanding memory arbiter with dcache
// priority, bounded icache starvation, and routing of read beats to the owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int BEATS     = 4,
  parameter int MAX_D_RUN = 4
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic        ic_req_valid,
  output logic        ic_req_ready,
  input  logic [31:0] ic_req_addr,

  input  logic        dc_req_valid,
  output logic        dc_req_ready,
  input  logic        dc_req_rnw,
  input  logic [31:0] dc_req_addr,
  input  logic [31:0] dc_req_wdata,
  input  logic [3:0]  dc_req_wmask,

  output logic        ic_resp_valid,
  output logic        dc_resp_valid,
  output logic [31:0] resp_data,

  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rnw,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,

  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  logic [1:0]            state_q, state_d;
  logic [BEAT_CNT_W-1:0] beat_q, beat_d;
  logic [D_RUN_W-1:0]    d_run_q, d_run_d;

  logic        in_idle;
  logic        d_run_full;
  logic        ic_win;
  logic        dc_win;
  logic        grant;
  logic        last_beat;
  logic        resp_beat;

  req_fields_t       req_d;
  req_fields_t       req_q;
  logic [REQ_W-1:0]  req_q_bits;

  assign in_idle    = (state_q == ST_IDLE);
  assign d_run_full = (d_run_q == D_RUN_W'(MAX_D_RUN));
  assign last_beat  = (beat_q == BEAT_CNT_W'(BEATS - 1));

  // dcache normally wins; icache takes the slot once dcache has had its run.
  assign ic_win = in_idle && ic_req_valid && (!dc_req_valid || d_run_full);
  assign dc_win = in_idle && dc_req_valid && !ic_win;
  assign grant  = ic_win || dc_win;

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    req_d = '0;
    if (ic_win) begin
      req_d.owner = OWNER_IC;
      req_d.rnw   = 1'b1;
      req_d.addr  = ic_req_addr;
    end else begin
      req_d.owner = OWNER_DC;
      req_d.rnw   = dc_req_rnw;
      req_d.addr  = dc_req_addr;
      req_d.wdata = dc_req_wdata;
      req_d.wmask = dc_req_wmask;
    end
  end

  req_latch #(
    .W (REQ_W)
  ) u_req_latch (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (grant),
    .d_i     (req_d),
    .q_o     (req_q_bits)
  );

  assign req_q = req_q_bits;

  // Run length of dcache grants taken while icache was kept waiting.
  always_comb begin
    d_run_d = d_run_q;
    if (ic_win) begin
      d_run_d = '0;
    end else if (dc_win) begin
      if (!ic_req_valid) begin
        d_run_d = '0;
      end else if (!d_run_full) begin
        d_run_d = d_run_q + D_RUN_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (mem_req_ready) state_d = req_q.rnw ? ST_RESP : ST_IDLE;
      end
      ST_RESP: begin
        if (mem_resp_valid) begin
          if (last_beat) begin
            state_d = ST_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + BEAT_CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      d_run_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      d_run_q <= d_run_d;
    end
  end

  // Readies are combinational on the request valids, so gate them with reset.
  assign ic_req_ready = reset_n && ic_win;
  assign dc_req_ready = reset_n && dc_win;

  assign mem_req_valid = (state_q == ST_ISSUE);
  assign mem_req_rnw   = req_q.rnw;
  assign mem_req_addr  = req_q.addr;
  assign mem_req_wdata = req_q.wdata;
  assign mem_req_wmask = req_q.wmask;

  assign resp_beat     = (state_q == ST_RESP) && mem_resp_valid;
  assign ic_resp_valid = resp_beat && (req_q.owner == OWNER_IC);
  assign dc_resp_valid = resp_beat && (req_q.owner == OWNER_DC);
  assign resp_data     = resp_beat ? mem_resp_data : '0;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter BEATS, default 4, SHALL set the number of 32-bit response beats per read; legal values are 1..16.
REQ-002 Parameter MAX_D_RUN, default 4, SHALL set the number of consecutive dcache grants allowed while icache waits; legal values are 1..15.
REQ-003 Port `clk`, input, width 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port `reset_n`, input, width 1: reset SHALL be asynchronous and active-low.
REQ-005 Ports `ic_req_valid`/`ic_req_ready`, in/out, 1/1: icache request handshake; the icache issues reads only.
REQ-006 Port `ic_req_addr`, input, width 32: icache line address.
REQ-007 Ports `dc_req_valid`/`dc_req_ready`, in/out, 1/1: dcache request handshake.
REQ-008 Ports `dc_req_rnw`, `dc_req_addr`, `dc_req_wdata`, `dc_req_wmask`: inputs of width 1/32/32/4 giving read-not-write, address, write data and byte mask.
REQ-009 Ports `ic_resp_valid`, `dc_resp_valid`, `resp_data`: outputs of width 1/1/32 carrying routed read beats.
REQ-010 Ports `mem_req_valid`/`mem_req_ready`, out/in, 1/1: memory request handshake.
REQ-011 Ports `mem_req_rnw`, `mem_req_addr`, `mem_req_wdata`, `mem_req_wmask`: outputs of width 1/32/32/4.
REQ-012 Ports `mem_resp_valid`/`mem_resp_data`, in, 1/32: read beats from memory; memory cannot apply backpressure on them.

Function
REQ-013 The FSM SHALL have three states: IDLE, ISSUE and RESP; only one transaction SHALL be outstanding at a time.
REQ-014 IDLE: when a requester is valid, the arbiter SHALL pulse that requester's req_ready for one cycle, latch its request fields and owner, and go to ISSUE.
REQ-015 Grant priority SHALL be: dcache wins, except icache wins when ic_req_valid=1 and d_run==MAX_D_RUN.
REQ-016 d_run SHALL increment on each dcache grant made while ic_req_valid=1, and SHALL clear on any icache grant.
REQ-017 d_run SHALL also clear on a dcache grant made while ic_req_valid=0, and SHALL saturate at MAX_D_RUN.
REQ-018 ISSUE: mem_req_valid=1 SHALL drive the latched fields, which SHALL stay stable until the cycle in which mem_req_ready=1.
REQ-019 On acceptance in ISSUE, a read SHALL go to RESP and a write SHALL go to IDLE.
REQ-020 RESP: each mem_resp_valid beat SHALL appear combinationally on resp_data with the owner's resp_valid asserted and the other resp_valid at 0.
REQ-021 A beat counter SHALL advance once per beat; after beat BEATS-1 the FSM SHALL enter IDLE and the counter SHALL wrap to 0.
REQ-022 mem_resp_valid outside RESP SHALL be ignored, and both resp_valid outputs SHALL stay 0.
REQ-023 Both req_ready outputs SHALL be 0 outside IDLE; a requester held valid through a busy period SHALL be serviced in a later IDLE cycle.
REQ-024 Minimum read latency SHALL be: grant at cycle N, mem_req_valid at N+1, and IDLE again the cycle after the last beat.
REQ-025 The block SHALL have no idle-cycle bypass: back-to-back transactions SHALL be separated by at least one IDLE cycle.
REQ-026 When both requesters are valid in the same cycle, exactly one SHALL be granted per REQ-015; the loser SHALL receive no ready.

Reset
REQ-027 While reset_n=0 the block SHALL be in IDLE with beat counter=0, d_run=0 and owner=dcache.
REQ-028 While reset_n=0 all valid and ready outputs SHALL be 0, and mem_req_* and resp_data SHALL be 0.
REQ-029 Reset asserted mid-ISSUE or mid-RESP SHALL abandon the transaction immediately, with no further resp_valid.
REQ-030 After reset_n rises, the first grant SHALL occur no earlier than the first rising edge.

Structure
REQ-031 The FSM state encodings (IDLE=2'd0, ISSUE=2'd1, RESP=2'd2) SHALL be defined in the shared constants header alongside the existing pipeline constants.
REQ-032 The owner encoding (OWNER_DC=1'b0, OWNER_IC=1'b1) SHALL also be defined in the shared constants header.
REQ-033 The latched request fields SHALL use one sub-module, `req_latch`: a clock-enabled register with asynchronous active-low reset.
REQ-034 All other logic SHALL be flat inside mem_arbiter.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- icache read of 0x100, mem_req_ready held 1, 4 beats 0xA0..0xA3 → ic_resp_valid on exactly 4 cycles with data 0xA0..0xA3, dc_resp_valid=0, back in IDLE the cycle after the 4th beat.
- dcache write of 0x200, data 0xDEADBEEF, mask 4'b0011, mem_req_ready=0 for 3 cycles → mem_req fields stable for all 3 cycles, transaction accepted on the 4th cycle, IDLE next, no resp_valid.
- Both requesters valid in the same cycle, d_run=0 → dcache granted, ic_req_ready=0.
- Both requesters held valid continuously, MAX_D_RUN=4 → grant order D,D,D,D,I,D,D,D,D,I.
- reset_n pulsed low during RESP after beat 1 → all outputs 0 at once, later beats ignored, the next request is served normally.
- mem_resp_valid pulsed while IDLE → no resp_valid and no state change.
